// File: rtl/chacha_avmm_pkg.sv
// rtl/chacha_avmm_pkg.sv - shared state encoding and bus constants for the ChaCha20 Avalon-MM host and agents
package chacha_avmm_pkg;

  localparam int DATA_W      = 32;
  localparam int AVMM_ADDR_W = 2;
  localparam int AVMM_LEN_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_WR_BUS   = 3'd4,
    ST_DONE     = 3'd5
  } avmm_state_e;

endpackage

// File: rtl/avmm_block_master.sv
// rtl/avmm_block_master.sv - Avalon-MM host moving a block of words to/from a word-addressed agent
// Optional AVMM_WAITREQUEST_EN adds a waitrequest input that stretches read/write strobes.
module avmm_block_master
  import chacha_avmm_pkg::*;
#(
  parameter int ADDR_W       = AVMM_ADDR_W,
  parameter int LEN_W        = AVMM_LEN_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
`ifdef AVMM_WAITREQUEST_EN
  input  logic              waitrequest,
`endif
  input  logic [DATA_W-1:0] readdata
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  avmm_state_e       r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr_q, w_addr_next;
  logic [LEN_W-1:0]  r_rem_q, w_rem_next;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic              w_sample;
  logic              w_wait;
  logic              r_read, r_write, r_cs;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writedata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

`ifdef AVMM_WAITREQUEST_EN
  assign w_wait = waitrequest;
`else
  assign w_wait = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr_q;
    w_rem_next   = r_rem_q;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_addr_next = cmd_base;
          w_rem_next  = cmd_len;
          if (cmd_len == '0)   w_state_next = ST_DONE;
          else if (cmd_write)  w_state_next = ST_WR_ISSUE;
          else                 w_state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (!w_wait) w_state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == CNT_W'(1)) begin
          w_sample     = 1'b1;
          w_addr_next  = r_addr_q + 1'b1;
          w_rem_next   = r_rem_q - 1'b1;
          w_state_next = (r_rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        if (wr_valid) w_state_next = ST_WR_BUS;
      end
      ST_WR_BUS: begin
        if (!w_wait) begin
          w_addr_next  = r_addr_q + 1'b1;
          w_rem_next   = r_rem_q - 1'b1;
          w_state_next = (r_rem_q == LEN_W'(1)) ? ST_DONE : ST_WR_ISSUE;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so they line up exactly with RD_ISSUE/WR_BUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr_q    <= '0;
      r_rem_q     <= '0;
      r_lat_cnt   <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_cs        <= 1'b0;
      r_address   <= '0;
      r_writedata <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_addr_q <= w_addr_next;
      r_rem_q  <= w_rem_next;
      if (r_state == ST_RD_ISSUE)
        r_lat_cnt <= CNT_W'(READ_LATENCY);
      else if (r_state == ST_RD_WAIT)
        r_lat_cnt <= r_lat_cnt - 1'b1;
      r_read    <= (w_state_next == ST_RD_ISSUE);
      r_write   <= (w_state_next == ST_WR_BUS);
      r_cs      <= (w_state_next == ST_RD_ISSUE) || (w_state_next == ST_WR_BUS);
      r_address <= ((w_state_next == ST_RD_ISSUE) || (w_state_next == ST_WR_BUS)) ? w_addr_next : '0;
      if (r_state == ST_WR_ISSUE && wr_valid)
        r_writedata <= wr_data;
      r_rd_valid <= w_sample;
      if (w_sample)
        r_rd_data <= readdata;
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign wr_ready   = (r_state == ST_WR_ISSUE);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign address    = r_address;
  assign chipselect = r_cs;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

endmodule
